// File: rtl/alu_sched_pkg.sv
// Shared types and widths for the ALU scheduler slice.
// Opcodes 9..15 are legal on the wire and are carried as raw OP_W-bit values.
package alu_sched_pkg;

  localparam int DATA_W = 64;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND    = 4'd0,
    OP_OR     = 4'd1,
    OP_NOT    = 4'd2,
    OP_ADD    = 4'd3,
    OP_SUB    = 4'd4,
    OP_INC    = 4'd5,
    OP_SHL    = 4'd6,
    OP_SHR    = 4'd7,
    OP_POPCNT = 4'd8
  } alu_op_e;

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the lowest index at or after ptr (mod N) wins.
// The priority pointer register is owned by the instantiating module.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  localparam int CW = IW + 1;
  localparam logic [CW-1:0] N_W = CW'(N);

  logic [CW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      // ptr + k never reaches 2N, so one conditional subtract is the modulo.
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (en && !found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
        grant[cand[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one fixed-latency pipelined ALU among N_REQ requesters, tagging each issued op
// with its requester index so results are routed back in issue order.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ALU_LAT = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  output logic [N_REQ-1:0]              req_ready,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_a,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_b,
  input  logic [N_REQ-1:0][OP_W-1:0]    req_op,
  output logic [DATA_W-1:0]             alu_a,
  output logic [DATA_W-1:0]             alu_b,
  output logic [OP_W-1:0]               alu_op,
  output logic                          alu_valid_i,
  input  logic [DATA_W-1:0]             alu_z,
  input  logic                          alu_valid_o,
  output logic [N_REQ-1:0]              resp_valid,
  output logic [DATA_W-1:0]             resp_z,
  output logic                          busy,
  output logic                          err
);

  localparam int IDX_W = $clog2(N_REQ);
  // The tag for an op is pushed one cycle before it enters the ALU, so at full rate
  // ALU_LAT+1 tags are outstanding when the oldest result returns; one extra slot
  // lets that cycle's push proceed without looking at alu_valid_o.
  localparam int TAG_DEPTH = ALU_LAT + 2;
  localparam int PTR_W     = $clog2(TAG_DEPTH);
  localparam int CNT_W     = $clog2(TAG_DEPTH + 1);
  localparam int DRN_W     = $clog2(ALU_LAT + 2);

  localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TAG_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(TAG_DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_REQ - 1);

  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              alu_valid_i_q, alu_valid_i_d;
  logic [N_REQ-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_z_q, resp_z_d;
  logic              err_q, err_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  tag_mem_q [TAG_DEPTH];
  logic [IDX_W-1:0]  tag_mem_d [TAG_DEPTH];

  logic              draining, issue_ok, push, pop, spurious;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;

  assign draining = (drain_q != '0);
  assign issue_ok = !draining && (cnt_q < CNT_MAX);

  rr_arbiter #(.N(N_REQ), .IW(IDX_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (issue_ok),
    .grant (grant),
    .idx   (grant_idx)
  );

  // A request transfers when req_valid[i] && req_ready[i]; at most one ready bit is
  // high, and ready never depends on alu_valid_o.
  assign req_ready = grant;
  assign push      = |grant;
  assign pop       = alu_valid_o && !draining && (cnt_q != '0);
  assign spurious  = alu_valid_o && !draining && (cnt_q == '0);

  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    alu_valid_i_d = push;
    resp_valid_d  = '0;
    resp_z_d      = resp_z_q;
    err_d         = err_q | spurious;
    drain_d       = draining ? drain_q - 1'b1 : drain_q;
    ptr_d         = ptr_q;
    wr_d          = wr_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    tag_mem_d     = tag_mem_q;

    if (push) begin
      alu_a_d            = req_a[grant_idx];
      alu_b_d            = req_b[grant_idx];
      alu_op_d           = req_op[grant_idx];
      tag_mem_d[wr_q]    = grant_idx;
      wr_d               = (wr_q == PTR_LAST) ? '0 : wr_q + 1'b1;
      ptr_d              = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
    end

    if (pop) begin
      resp_valid_d = N_REQ'(1) << tag_mem_q[rd_q];
      resp_z_d     = alu_z;
      rd_d         = (rd_q == PTR_LAST) ? '0 : rd_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      alu_valid_i_q <= 1'b0;
      resp_valid_q  <= '0;
      resp_z_q      <= '0;
      err_q         <= 1'b0;
      drain_q       <= DRAIN_LOAD;
      ptr_q         <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
    end else begin
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      alu_valid_i_q <= alu_valid_i_d;
      resp_valid_q  <= resp_valid_d;
      resp_z_q      <= resp_z_d;
      err_q         <= err_d;
      drain_q       <= drain_d;
      ptr_q         <= ptr_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
    end
  end

  // Tag storage needs no reset: occupancy is governed by cnt_q.
  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_valid_i = alu_valid_i_q;
  assign resp_valid  = resp_valid_q;
  assign resp_z      = resp_z_q;
  assign err         = err_q;
  assign busy        = draining || (cnt_q != '0);

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: a reset-less pipelined ALU model, table-driven single ops,
// and hand-written drain, contention, spurious-result and mid-flight reset sequences.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int N_REQ   = 4;
  localparam int ALU_LAT = 6;
  localparam int EW      = 32 + 8 + 1 + 64;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [N_REQ-1:0]            req_valid = '0;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][63:0]      req_a = '0;
  logic [N_REQ-1:0][63:0]      req_b = '0;
  logic [N_REQ-1:0][3:0]       req_op = '0;
  logic [63:0]                 alu_a, alu_b, alu_z;
  logic [3:0]                  alu_op;
  logic                        alu_valid_i, alu_valid_o;
  logic [N_REQ-1:0]            resp_valid;
  logic [63:0]                 resp_z;
  logic                        busy, err;

  alu_sched #(.N_REQ(N_REQ), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_valid_i(alu_valid_i),
    .alu_z(alu_z), .alu_valid_o(alu_valid_o),
    .resp_valid(resp_valid), .resp_z(resp_z), .busy(busy), .err(err)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: valid pipeline has no reset, like the real instance
  logic [ALU_LAT-1:0] pipe_v = '0;
  logic [63:0]        pipe_z [ALU_LAT];
  logic [63:0]        alu_res;
  logic               spur = 1'b0;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0: alu_res = alu_a & alu_b;
      4'd1: alu_res = alu_a | alu_b;
      4'd2: alu_res = ~alu_a;
      4'd3: alu_res = alu_a + alu_b;
      4'd4: alu_res = alu_a - alu_b;
      4'd5: alu_res = alu_a + 64'd1;
      4'd6: alu_res = alu_a << alu_b[5:0];
      4'd7: alu_res = alu_a >> alu_b[5:0];
      4'd8: alu_res = 64'($countones(alu_a));
      default: alu_res = '0;
    endcase
  end

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[ALU_LAT-2:0], alu_valid_i};
    pipe_z[0] <= alu_res;
    for (int i = 1; i < ALU_LAT; i++) pipe_z[i] <= pipe_z[i-1];
  end

  assign alu_valid_o = pipe_v[ALU_LAT-1] | spur;
  assign alu_z       = pipe_z[ALU_LAT-1];

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_push(input int id, input logic [63:0] z, input bit chk, input int t);
    exp_q.push_back({32'(t), 8'(id), chk, z});
  endtask

  always @(negedge clk) begin
    if (mon_en && resp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: resp_valid=%b resp_z=%0h expected no response", resp_valid, resp_z);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("resp_valid", 64'(resp_valid), 64'(4'b0001 << e[72:65]));
        if (e[64]) check("resp_z", resp_z, e[63:0]);
        check("resp_cycle", 64'(cyc), 64'(e[104:73]));
      end
    end
  end

  // driver tasks
  task automatic send(input int id, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] op, input logic [63:0] z, input bit chk, input bit track);
    int n;
    n = 0;
    req_a[id] = a; req_b[id] = b; req_op[id] = op; req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("handshake", 64'(req_ready[id]), 64'd1);
    if (!req_ready[id]) begin
      req_valid[id] = 1'b0;
      return;
    end
    if (track) sb_push(id, z, chk, cyc + 8);
    @(negedge clk);
    req_valid[id] = 1'b0;
    check("issue_valid", 64'(alu_valid_i), 64'd1);
    check("issue_op", 64'(alu_op), 64'(op));
    check("issue_a", alu_a, a);
    check("issue_b", alu_b, b);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk); n++;
    end
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    int          id;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [63:0] z;
    bit          chk;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 64'd5, 64'd3, OP_ADD, 64'd8, 1'b1};
    vecs[1] = '{1, 64'hF0F0, 64'h0FF0, OP_AND, 64'h00F0, 1'b1};
    vecs[2] = '{2, 64'hFFFF_0000_0000_000F, 64'd0, OP_POPCNT, 64'd20, 1'b1};
    vecs[3] = '{3, 64'd1, 64'd2, OP_OR, 64'd3, 1'b1};
    vecs[4] = '{0, 64'd0, 64'd0, OP_NOT, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[5] = '{1, 64'd3, 64'd5, OP_SUB, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    vecs[6] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, OP_INC, 64'd0, 1'b1};
    vecs[7] = '{3, 64'd1, 64'd63, OP_SHL, 64'h8000_0000_0000_0000, 1'b1};
    vecs[8] = '{0, 64'h8000_0000_0000_0000, 64'd4, OP_SHR, 64'h0800_0000_0000_0000, 1'b1};
    vecs[9] = '{1, 64'd1, 64'd2, 4'd12, 64'd0, 1'b0};

    // reset with every requester asking
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i]  = 64'(i) * 64'h1_0000 + 64'd1;
      req_b[i]  = 64'(i + 1);
      req_op[i] = OP_ADD;
    end
    req_valid = '1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_alu_valid_i", 64'(alu_valid_i), 64'd0);
    check("rst_alu_a", alu_a, 64'd0);
    check("rst_alu_b", alu_b, 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_z", resp_z, 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // drain: 7 cycles of no ready, then requester 0 wins
    for (int i = 0; i < 7; i++) begin
      #1;
      check("drain_ready", 64'(req_ready), 64'd0);
      check("drain_busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    #1;

    // contention: round-robin one grant per cycle, operands change after each transfer
    for (int k = 0; k < 12; k++) begin
      int id;
      id = k % N_REQ;
      check("rr_grant", 64'(req_ready), 64'(4'b0001 << id));
      sb_push(id, req_a[id] + req_b[id], 1'b1, cyc + 8);
      @(posedge clk); #1;
      req_a[id] = req_a[id] + 64'h0123_4567_89AB_CDEF;
      req_b[id] = req_b[id] ^ 64'hFFFF_0000_FFFF_0000;
      @(negedge clk); #1;
    end
    req_valid = '0;
    wait_idle();

    // table of single ops
    for (int v = 0; v < 10; v++) begin
      send(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].z, vecs[v].chk, 1'b1);
      wait_idle();
    end
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_err", 64'(err), 64'd0);

    // spurious result with nothing outstanding
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("spur_err", 64'(err), 64'd1);
    check("spur_resp", 64'(resp_valid), 64'd0);
    repeat (3) @(negedge clk);
    check("spur_err_sticky", 64'(err), 64'd1);

    // mid-flight reset: three ops in flight are discarded
    send(0, 64'd10, 64'd1, OP_ADD, 64'd11, 1'b1, 1'b0);
    send(1, 64'd20, 64'd2, OP_ADD, 64'd22, 1'b1, 1'b0);
    send(2, 64'd30, 64'd3, OP_ADD, 64'd33, 1'b1, 1'b0);
    check("inflight_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1000;
    check("mid_rst_err", 64'(err), 64'd0);
    for (int i = 0; i < 7; i++) begin
      #1;
      check("mid_drain_ready", 64'(req_ready), 64'd0);
      check("mid_drain_busy", 64'(busy), 64'd1);
      check("mid_no_resp", 64'(resp_valid), 64'd0);
      @(negedge clk);
    end
    #1;
    check("mid_post_busy", 64'(busy), 64'd0);
    check("mid_post_ready", 64'(req_ready), 64'b1000);
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mid_no_resp_late", 64'(resp_valid), 64'd0);
    end
    check("mid_err_clear", 64'(err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
